// File: rtl/morse_key_decoder.sv
// rtl/morse_key_decoder.sv - single-key Morse receiver with gap timing, A-Z/0-9 decode and code history
module morse_key_decoder #(
  parameter int CNT_W      = 8,
  parameter int GLITCH_MIN = 2,
  parameter int DASH_MIN   = 6,
  parameter int LETTER_GAP = 6,
  parameter int WORD_GAP   = 14,
  parameter int DEPTH      = 4
) (
  input  logic               Clock,
  input  logic               reset,
  input  logic               key,
  output logic               char_valid,
  output logic [5:0]         char_code,
  output logic               err,
  output logic               busy,
  output logic [6*DEPTH-1:0] hist
);

  typedef enum logic [1:0] {IDLE, MARK, SPACE, WORDWAIT} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX    = '1;
  localparam logic [CNT_W-1:0] GLITCH_C   = CNT_W'(GLITCH_MIN);
  localparam logic [CNT_W-1:0] DASH_C     = CNT_W'(DASH_MIN);
  localparam logic [CNT_W-1:0] LETTER_C   = CNT_W'(LETTER_GAP);
  localparam logic [CNT_W-1:0] WORD_C     = CNT_W'(WORD_GAP);
  localparam logic [5:0]       CODE_SPACE = 6'd37;
  localparam logic [5:0]       CODE_ERR   = 6'd63;

  state_t           state;
  logic [CNT_W-1:0] mark_cnt;
  logic [CNT_W-1:0] gap_cnt;
  logic [2:0]       sym_len;
  logic [4:0]       sym_pat;
  logic             ovf;
  logic             from_ww;

  logic [CNT_W-1:0] mark_inc;
  logic [CNT_W-1:0] gap_inc;
  logic             is_dash;
  logic             press_ok;
  logic [2:0]       app_len;
  logic [4:0]       app_pat;
  logic             app_ovf;
  logic             commit_chr;
  logic             commit_sp;
  logic             commit;
  logic [5:0]       commit_code;
  logic [6*DEPTH-1:0] hist_next;

  // Key is {len, pat}; with fewer than 5 symbols the unused upper pattern bits are zero.
  function automatic logic [5:0] decode(input logic [2:0] len, input logic [4:0] pat, input logic ov);
    if (ov) return CODE_ERR;
    case ({len, pat})
      8'b001_00000: return 6'd5;
      8'b001_00001: return 6'd20;
      8'b010_00001: return 6'd1;
      8'b010_00000: return 6'd9;
      8'b010_00011: return 6'd13;
      8'b010_00010: return 6'd14;
      8'b011_00100: return 6'd4;
      8'b011_00110: return 6'd7;
      8'b011_00101: return 6'd11;
      8'b011_00111: return 6'd15;
      8'b011_00010: return 6'd18;
      8'b011_00000: return 6'd19;
      8'b011_00001: return 6'd21;
      8'b011_00011: return 6'd23;
      8'b100_01000: return 6'd2;
      8'b100_01010: return 6'd3;
      8'b100_00010: return 6'd6;
      8'b100_00000: return 6'd8;
      8'b100_00111: return 6'd10;
      8'b100_00100: return 6'd12;
      8'b100_00110: return 6'd16;
      8'b100_01101: return 6'd17;
      8'b100_00001: return 6'd22;
      8'b100_01001: return 6'd24;
      8'b100_01011: return 6'd25;
      8'b100_01100: return 6'd26;
      8'b101_11111: return 6'd27;
      8'b101_01111: return 6'd28;
      8'b101_00111: return 6'd29;
      8'b101_00011: return 6'd30;
      8'b101_00001: return 6'd31;
      8'b101_00000: return 6'd32;
      8'b101_10000: return 6'd33;
      8'b101_11000: return 6'd34;
      8'b101_11100: return 6'd35;
      8'b101_11110: return 6'd36;
      default:      return CODE_ERR;
    endcase
  endfunction

  always_comb begin
    mark_inc = (mark_cnt == CNT_MAX) ? mark_cnt : mark_cnt + 1'b1;
    gap_inc  = (gap_cnt == CNT_MAX) ? gap_cnt : gap_cnt + 1'b1;
    is_dash  = (mark_cnt >= DASH_C);
    press_ok = (mark_cnt >= GLITCH_C);
    app_ovf  = ovf | (sym_len == 3'd5);
    app_len  = (sym_len == 3'd5) ? 3'd5 : sym_len + 3'd1;
    app_pat  = {sym_pat[3:0], is_dash};
  end

  // With a one-cycle letter gap the release edge itself ends the character.
  always_comb begin
    commit_chr = !key && (((state == SPACE) && (gap_inc == LETTER_C)) ||
                          ((state == MARK) && press_ok && (LETTER_GAP == 1)));
    commit_sp  = !key && (state == WORDWAIT) && (gap_inc == WORD_C);
    commit     = commit_chr | commit_sp;
    commit_code = CODE_SPACE;
    if (commit_chr) begin
      commit_code = (state == MARK) ? decode(app_len, app_pat, app_ovf)
                                    : decode(sym_len, sym_pat, ovf);
    end
  end

  generate
    if (DEPTH > 1) begin : g_shift
      assign hist_next = {hist[6*DEPTH-7:0], commit_code};
    end else begin : g_single
      assign hist_next = commit_code;
    end
  endgenerate

  always_ff @(posedge Clock) begin
    if (reset) begin
      state    <= IDLE;
      mark_cnt <= '0;
      gap_cnt  <= '0;
      sym_len  <= '0;
      sym_pat  <= '0;
      ovf      <= 1'b0;
      from_ww  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (key) begin
            state    <= MARK;
            mark_cnt <= 1;
            from_ww  <= 1'b0;
            busy     <= 1'b1;
          end
        end
        MARK: begin
          if (key) begin
            mark_cnt <= mark_inc;
          end else if (!press_ok) begin
            // Glitch: resume the gap that was running, gap_cnt untouched.
            if (sym_len != 3'd0) begin
              state <= SPACE;
            end else if (from_ww) begin
              state <= WORDWAIT;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            gap_cnt <= 1;
            if (commit_chr) begin
              state   <= WORDWAIT;
              sym_len <= '0;
              sym_pat <= '0;
              ovf     <= 1'b0;
            end else begin
              state   <= SPACE;
              sym_len <= app_len;
              sym_pat <= app_pat;
              ovf     <= app_ovf;
            end
          end
        end
        SPACE: begin
          if (key) begin
            state    <= MARK;
            mark_cnt <= 1;
            from_ww  <= 1'b0;
          end else begin
            gap_cnt <= gap_inc;
            if (commit_chr) begin
              state   <= WORDWAIT;
              sym_len <= '0;
              sym_pat <= '0;
              ovf     <= 1'b0;
            end
          end
        end
        WORDWAIT: begin
          if (key) begin
            state    <= MARK;
            mark_cnt <= 1;
            from_ww  <= 1'b1;
          end else begin
            gap_cnt <= gap_inc;
            if (commit_sp) begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clock) begin
    if (reset) begin
      hist       <= '0;
      char_code  <= '0;
      char_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      char_valid <= commit;
      err        <= commit && (commit_code == CODE_ERR);
      if (commit) begin
        char_code <= commit_code;
        hist      <= hist_next;
      end
    end
  end

endmodule
